output_drain: RTL and testbench

Post-processing and drain stage directly downstream of the convolution chip. It consumes the per-pixel result strobe (`out`, `output_valid`, `output_x/y/ch`), applies optional ReLU, an arithmetic right-shift and saturation, and buffers each result in a small FIFO. Results leave on a valid/ready stream towards the host/testbench. The controller cannot be back-pressured, so the block flags overflow and signals completion once every expected output has been drained.

---
 rtl/output_drain_pkg.sv | 46 ++++
 rtl/output_drain_if.sv | 47 ++++
 rtl/output_drain_sync_fifo.sv | 46 ++++
 rtl/output_drain.sv | 112 +++++++++++
 tb/tb_output_drain.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/output_drain_pkg.sv
// Shared types and helpers for the output drain stage: FIFO record, FSM
// encoding, result count and the ReLU/shift/saturate post-processor.
package output_drain_pkg;

  // Record fields are sized for the widest configuration; narrower
  // instances zero-extend coordinates and truncate on the way out.
  localparam int REC_DATA_W  = 16;
  localparam int REC_COORD_W = 16;

  typedef struct packed {
    logic signed [REC_DATA_W-1:0]  data;
    logic        [REC_COORD_W-1:0] x;
    logic        [REC_COORD_W-1:0] y;
    logic        [REC_COORD_W-1:0] ch;
  } out_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } drain_state_e;

  function automatic int total_count(input int w, input int h, input int ch);
    return w * h * ch;
  endfunction

  function automatic logic signed [31:0] post_process(
    input logic signed [31:0] d,
    input int                 shift,
    input int                 out_w,
    input bit                 relu
  );
    logic signed [31:0] v;
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    v  = (relu && d < 0) ? 32'sd0 : d;
    s  = v >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/output_drain_if.sv
// Result-in / drain-out bundle of the output drain stage, plus its status.
interface output_drain_if
  import output_drain_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int OUT_WIDTH          = 8,
  parameter int FIFO_DEPTH         = 8,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
);
  localparam int XW    = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW    = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CHW   = $clog2(OUTPUT_NB_CHANNELS);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int TOTAL = total_count(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
  localparam int DRW   = $clog2(TOTAL + 1);

  logic                        in_valid;
  logic signed [IO_DATA_WIDTH-1:0] in_data;
  logic [XW-1:0]               in_x;
  logic [YW-1:0]               in_y;
  logic [CHW-1:0]              in_ch;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [XW-1:0]               out_x;
  logic [YW-1:0]               out_y;
  logic [CHW-1:0]              out_ch;
  logic [LW-1:0]               fifo_level;
  logic [DRW-1:0]              drained;
  logic                        overflow;
  logic                        stray;
  logic                        done;

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output out_valid, out_data, out_x, out_y, out_ch,
           fifo_level, drained, overflow, stray, done
  );

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  out_valid, out_data, out_x, out_y, out_ch,
           fifo_level, drained, overflow, stray, done
  );
endinterface

// File: rtl/output_drain_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; an extra pointer bit
// separates full from empty.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = LW'(wr_ptr - rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/output_drain.sv
// Post-processes conv results (ReLU, shift, saturate), buffers them and drains
// them on a valid/ready stream, flagging drops, strays and completion.
//   state   | meaning
//   IDLE    | after reset, waiting for start; in_valid is stray
//   RUN     | accepting results and draining the FIFO
//   DONE    | all TOTAL results drained; in_valid is stray
module output_drain
  import output_drain_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int OUT_WIDTH          = 8,
  parameter int SHIFT              = 4,
  parameter int RELU_EN            = 1,
  parameter int FIFO_DEPTH         = 8,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic           clk,
  input  logic           arst_n_in,
  input  logic           start,
  output_drain_if.slave  bus
);
  localparam int TOTAL = total_count(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
  localparam int XW    = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW    = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CHW   = $clog2(OUTPUT_NB_CHANNELS);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int DRW   = $clog2(TOTAL + 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]     state;
  logic [DRW-1:0] drained;
  logic           overflow;
  logic           stray;
  logic           in_run;
  logic           push;
  logic           pop;
  logic           empty;
  logic           full;
  logic [LW-1:0]  level;
  out_rec_t       wr_rec;
  out_rec_t       head;

  assign in_run = (state == S_RUN);
  // start flushes, so neither side of the FIFO moves in that cycle
  assign pop    = in_run && !empty && bus.out_ready && !start;
  assign push   = in_run && bus.in_valid && !start && (!full || pop);

  always_comb begin
    wr_rec      = '0;
    wr_rec.data = REC_DATA_W'(post_process(32'(bus.in_data), SHIFT, OUT_WIDTH, RELU_EN != 0));
    wr_rec.x    = REC_COORD_W'(bus.in_x);
    wr_rec.y    = REC_COORD_W'(bus.in_y);
    wr_rec.ch   = REC_COORD_W'(bus.in_ch);
  end

  sync_fifo #(
    .T     (out_rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (arst_n_in),
    .flush (start),
    .push  (push),
    .pop   (pop),
    .wdata (wr_rec),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state    <= S_IDLE;
      drained  <= '0;
      overflow <= 1'b0;
      stray    <= 1'b0;
    end else if (start) begin
      state    <= S_RUN;
      drained  <= '0;
      overflow <= 1'b0;
      stray    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (pop && drained != DRW'(TOTAL)) drained <= drained + 1'b1;
          if (pop && drained == DRW'(TOTAL - 1)) state <= S_DONE;
          if (bus.in_valid && full && !pop) overflow <= 1'b1;
        end
        default: begin
          if (bus.in_valid) stray <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out_valid  = in_run && !empty;
  assign bus.out_data   = bus.out_valid ? OUT_WIDTH'(head.data) : '0;
  assign bus.out_x      = bus.out_valid ? XW'(head.x)  : '0;
  assign bus.out_y      = bus.out_valid ? YW'(head.y)  : '0;
  assign bus.out_ch     = bus.out_valid ? CHW'(head.ch) : '0;
  assign bus.fifo_level = level;
  assign bus.drained    = drained;
  assign bus.overflow   = overflow;
  assign bus.stray      = stray;
  assign bus.done       = (state == S_DONE);
endmodule

// File: tb/tb_output_drain.sv
// Directed bench for output_drain on a 2x2x2 map (8 results), with a
// RELU-off twin instance fed the same stimulus.
module tb_output_drain;
  localparam int IOW = 16;
  localparam int OW  = 8;
  localparam int DEP = 8;
  localparam int W   = 2;
  localparam int H   = 2;
  localparam int CH  = 2;

  logic clk = 1'b0;
  logic arst_n_in;
  logic start;

  always #5 clk = ~clk;

  output_drain_if #(.IO_DATA_WIDTH(IOW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEP),
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(CH)) bus ();
  output_drain_if #(.IO_DATA_WIDTH(IOW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEP),
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(CH)) bus_nr ();

  output_drain #(.IO_DATA_WIDTH(IOW), .OUT_WIDTH(OW), .SHIFT(4), .RELU_EN(1), .FIFO_DEPTH(DEP),
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(CH)) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .start     (start),
    .bus       (bus)
  );

  output_drain #(.IO_DATA_WIDTH(IOW), .OUT_WIDTH(OW), .SHIFT(4), .RELU_EN(0), .FIFO_DEPTH(DEP),
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(CH)) dut_nr (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .start     (start),
    .bus       (bus_nr)
  );

  assign bus_nr.in_valid  = bus.in_valid;
  assign bus_nr.in_data   = bus.in_data;
  assign bus_nr.in_x      = bus.in_x;
  assign bus_nr.in_y      = bus.in_y;
  assign bus_nr.in_ch     = bus.in_ch;
  assign bus_nr.out_ready = bus.out_ready;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input int idx);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_x     = 1'(idx);
    bus.in_y     = 1'(idx >> 1);
    bus.in_ch    = 1'(idx >> 2);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] head_got();
    return {21'd0, bus.out_data, bus.out_x, bus.out_y, bus.out_ch};
  endfunction

  // entry i carries data i*16 (-> i after the shift) and coords from i's bits
  function automatic logic [31:0] head_exp(input int i);
    logic [7:0] d;
    logic [2:0] c;
    d = 8'(i);
    c = 3'(i);
    return {21'd0, d, c[0], c[1], c[2]};
  endfunction

  initial begin
    arst_n_in     = 1'b0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done",      32'(bus.done), 32'd0);
    chk("rst_level",     32'(bus.fifo_level), 32'd0);
    chk("rst_drained",   32'(bus.drained), 32'd0);
    chk("rst_head",      head_got(), 32'd0);
    chk("rst_flags",     {30'd0, bus.overflow, bus.stray}, 32'd0);
    #10 arst_n_in = 1'b1;
    step();

    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("stray_idle", 32'(bus.stray), 32'd1);
    chk("idle_level", 32'(bus.fifo_level), 32'd0);

    start = 1'b1;
    bus.in_valid = 1'b1;
    step();
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("start_vs_valid_stray", 32'(bus.stray), 32'd0);
    chk("start_vs_valid_level", 32'(bus.fifo_level), 32'd0);

    push(16'h0123, 0);
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    chk("sat_mid",       {24'd0, bus.out_data}, 32'h12);
    chk("sat_mid_norelu", {24'd0, bus_nr.out_data}, 32'h12);
    push(16'h7FFF, 1);
    push(16'hFF9C, 2);
    chk("sat_level3", 32'(bus.fifo_level), 32'd3);
    chk("hold_head",  {24'd0, bus.out_data}, 32'h12);
    bus.out_ready = 1'b1;
    step();
    chk("sat_hi", {24'd0, bus.out_data}, 32'h7F);
    step();
    chk("relu_neg",   {24'd0, bus.out_data}, 32'h00);
    chk("norelu_neg", {24'd0, bus_nr.out_data}, 32'hF9);
    step();
    chk("sat_empty",   32'(bus.out_valid), 32'd0);
    chk("sat_drained", 32'(bus.drained), 32'd3);
    bus.out_ready = 1'b0;

    pulse_start();
    chk("bp_drained0", 32'(bus.drained), 32'd0);
    for (int i = 0; i < 8; i++) push(16'(i * 16), i);
    chk("bp_level8",    32'(bus.fifo_level), 32'd8);
    chk("bp_no_ovf",    32'(bus.overflow), 32'd0);
    push(16'h00F0, 0);
    chk("bp_ovf",       32'(bus.overflow), 32'd1);
    chk("bp_level_hold", 32'(bus.fifo_level), 32'd8);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_pop%0d", i), head_got(), head_exp(i));
      step();
    end
    chk("bp_done",      32'(bus.done), 32'd1);
    chk("bp_drained8",  32'(bus.drained), 32'd8);
    chk("bp_done_nov",  32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    pulse_start();
    for (int i = 0; i < 8; i++) push(16'(i * 16), i);
    bus.out_ready = 1'b1;
    push(16'h0080, 0);
    bus.out_ready = 1'b0;
    chk("fullpop_level", 32'(bus.fifo_level), 32'd8);
    chk("fullpop_novf",  32'(bus.overflow), 32'd0);
    chk("fullpop_drn",   32'(bus.drained), 32'd1);
    chk("fullpop_head",  head_got(), head_exp(1));
    push(16'h0010, 0);
    chk("fullpop_ovf",   32'(bus.overflow), 32'd1);
    pulse_start();
    chk("restart_level", 32'(bus.fifo_level), 32'd0);
    chk("restart_drn",   32'(bus.drained), 32'd0);
    chk("restart_flags", {30'd0, bus.overflow, bus.stray}, 32'd0);
    chk("restart_nov",   32'(bus.out_valid), 32'd0);

    push(16'h0030, 3);
    push(16'h0040, 4);
    chk("arst_pre_level", 32'(bus.fifo_level), 32'd2);
    #2 arst_n_in = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_level", 32'(bus.fifo_level), 32'd0);
    chk("arst_head",  head_got(), 32'd0);
    #3 arst_n_in = 1'b1;
    step();

    pulse_start();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(16'(i * 16), i);
    chk("stream_drn7",  32'(bus.drained), 32'd7);
    chk("stream_busy",  32'(bus.done), 32'd0);
    chk("stream_lvl1",  32'(bus.fifo_level), 32'd1);
    step();
    chk("stream_drn8",  32'(bus.drained), 32'd8);
    chk("stream_done",  32'(bus.done), 32'd1);
    chk("stream_nov",   32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("stray_done",   32'(bus.stray), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
